// File: rtl/control_pa5000_pkg.sv
// Shared constants for the PA5000 sequencer: select codes, state encoding, datapath width.
package control_pa5000_pkg;

  localparam int unsigned N        = 16;
  localparam int unsigned NumSteps = 5;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StI1    = 4'd1,
    StW1    = 4'd2,
    StI2    = 4'd3,
    StW2    = 4'd4,
    StI3    = 4'd5,
    StW3    = 4'd6,
    StI4    = 4'd7,
    StW4    = 4'd8,
    StI5    = 4'd9,
    StW5    = 4'd10,
    StShift = 4'd11
  } state_e;

  localparam logic [2:0] SelSFk  = 3'd0;
  localparam logic [2:0] SelSFk1 = 3'd1;
  localparam logic [2:0] SelSFk2 = 3'd2;
  localparam logic [2:0] SelSUk  = 3'd3;
  localparam logic [2:0] SelSYk  = 3'd4;

  localparam logic [1:0] SelCCa1 = 2'd0;
  localparam logic [1:0] SelCCa2 = 2'd1;
  localparam logic [1:0] SelCCb0 = 2'd2;
  localparam logic [1:0] SelCCb1 = 2'd3;

  localparam logic [2:0] SelZZero  = 3'd0;
  localparam logic [2:0] SelZAcum1 = 3'd1;
  localparam logic [2:0] SelZAcum2 = 3'd2;
  localparam logic [2:0] SelZAcum3 = 3'd3;
  localparam logic [2:0] SelZUk    = 3'd4;

endpackage

// File: rtl/control_pa5000_decod.sv
// Moore output decode for the PA5000 sequencer: state in, enables/selects/status out.
module decodpa5000
  import control_pa5000_pkg::*;
(
  input  state_e     state,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic [2:0] selmuxS,
  output logic [1:0] selmuxC,
  output logic [2:0] selmuxZ,
  output logic       busy,
  output logic       done
);

  always_comb begin
    en1     = 1'b0;
    en2     = 1'b0;
    en3     = 1'b0;
    en4     = 1'b0;
    en5     = 1'b0;
    en6     = 1'b0;
    en7     = 1'b0;
    selmuxS = SelSFk;
    selmuxC = SelCCa1;
    selmuxZ = SelZZero;
    busy    = (state != StIdle);
    done    = (state == StShift);
    // Issue and write cycles share selects; only the write cycle fires the enable.
    unique case (state)
      StI1, StW1: begin
        selmuxS = SelSFk1;
        selmuxC = SelCCa1;
        selmuxZ = SelZUk;
        en5     = (state == StW1);
      end
      StI2, StW2: begin
        selmuxS = SelSFk2;
        selmuxC = SelCCa2;
        selmuxZ = SelZAcum1;
        en2     = (state == StW2);
      end
      StI3, StW3: begin
        selmuxS = SelSFk;
        selmuxC = SelCCb0;
        selmuxZ = SelZZero;
        en6     = (state == StW3);
      end
      StI4, StW4: begin
        selmuxS = SelSFk1;
        selmuxC = SelCCb1;
        selmuxZ = SelZAcum2;
        en7     = (state == StW4);
      end
      StI5, StW5: begin
        selmuxS = SelSFk2;
        selmuxC = SelCCb0;
        selmuxZ = SelZAcum3;
        en1     = (state == StW5);
      end
      StShift: begin
        en3 = 1'b1;
        en4 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_pa5000.sv
// Sequencer for the 5 kHz high-pass biquad datapath: 11-cycle micro-program per start strobe.
module control_pa5000
  import control_pa5000_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic [2:0] selmuxS,
  output logic [1:0] selmuxC,
  output logic [2:0] selmuxZ,
  output logic       busy,
  output logic       done
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StShift: state_d = start ? StI1 : StIdle;
      StI1, StW1, StI2, StW2, StI3, StW3, StI4, StW4, StI5, StW5:
        state_d = state_e'(state_q + 4'd1);
      default: state_d = StIdle;
    endcase
  end

  decodpa5000 u_decod (
    .state   (state_q),
    .en1     (en1),
    .en2     (en2),
    .en3     (en3),
    .en4     (en4),
    .en5     (en5),
    .en6     (en6),
    .en7     (en7),
    .selmuxS (selmuxS),
    .selmuxC (selmuxC),
    .selmuxZ (selmuxZ),
    .busy    (busy),
    .done    (done)
  );

endmodule

// File: doc/control_pa5000.md
# control_pa5000

Sequencer for the 5 kHz high-pass second-order section datapath. On each `start` strobe it runs a fixed 11-cycle micro-program, driving the datapath's seven register enables and three operand-mux selects. The schedule computes F(k) = U(k) + CA1·F(k-1) + CA2·F(k-2) and then Y(k) = CB0·F(k) + CB1·F(k-1) + CB0·F(k-2); feedback coefficients are stored pre-negated. When the result is complete it shifts the delay line and pulses `done`. It sits between the sample-rate timer / ADC interface and the filter datapath.

## Interface
Parameters: none. All widths and codes come from `constantes.h`.

Ports:
- clk  in  1  system clock; every transition happens on the rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  new sample on `uk` is valid; accepted only in IDLE or SHIFT
- en1..en7  out  1 each  enables for the datapath registers: Y(k), F(k), F(k-1), F(k-2), acum1, acum2, acum3
- selmuxS  out  3  signal-operand select: FK=0, FK1=1, FK2=2, UK=3, YK=4
- selmuxC  out  2  coefficient select: CA1=0, CA2=1, CB0=2, CB1=3
- selmuxZ  out  3  addend select: ZERO=0, ACUM1=1, ACUM2=2, ACUM3=3, UK=4
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; Y(k) is valid on the datapath output while it is high

## Operation
- The arithmetic unit computes dato1·dato2 + dato3 and registers the result, so it has 1 cycle of latency.
  - Each step is therefore an issue cycle (I), which drives the selects, followed by a write cycle (W), which holds the same selects and asserts one enable.
  - No pipelining across steps, so there are no read-after-write hazards on the acumulators.
- States: IDLE, I1, W1, I2, W2, I3, W3, I4, W4, I5, W5, SHIFT. Binary encoding, defined in `constantes.h`.
- Step table (S, C, Z, then the enable asserted in W):
  - Step 1: FK1, CA1, UK; en5 writes acum1 = U + CA1·F1
  - Step 2: FK2, CA2, ACUM1; en2 writes F(k)
  - Step 3: FK, CB0, ZERO; en6 writes acum2
  - Step 4: FK1, CB1, ACUM2; en7 writes acum3
  - Step 5: FK2, CB0, ACUM3; en1 writes Y(k)
- SHIFT: en3 and en4 are asserted together. Both registers sample pre-edge values, so F(k-2) takes the old F(k-1) and F(k-1) takes F(k). `done` is high.
- Transitions:
  - IDLE goes to I1 if `start`, otherwise stays in IDLE.
  - I1 through W5 advance unconditionally.
  - SHIFT goes to I1 if `start` (back-to-back samples), otherwise to IDLE.
- `start` in any other state is ignored. It is not queued.
- Outputs are Moore-decoded from the state register only. In IDLE all enables are 0 and all selects are 0.
- At most one of en1, en2, en5, en6, en7 is high in any cycle. en3 and en4 are high only in SHIFT.

## Timing
- Reset (reset=0, applied asynchronously):
  - state goes to IDLE immediately
  - all enables, `busy` and `done` go to 0, and all selects go to 0
- Reset mid-sequence aborts it. The datapath registers are cleared by the same reset net, so no partial state survives.
- Latency: with `start` sampled high at edge 0, I1 occupies cycle 1, W5 occupies cycle 10 and SHIFT occupies cycle 11.
  - `done` is high for exactly cycle 11.
  - Y(k) is valid from cycle 11 until the next W5.
- `uk` must stay stable from the `start` edge through the end of I1, since it is captured by the arithmetic register at the close of I1.
- Throughput: one sample per 11 cycles when `start` is re-asserted in SHIFT, and one per 12 cycles when the block returns through IDLE.
- `busy` rises one cycle after `start` is accepted from IDLE. It stays high through SHIFT and stays high continuously on back-to-back runs.

## Structure
- `constantes.h` holds:
  - the S/C/Z select codes
  - the state encodings
  - `N`, plus a step-count constant of 5
- State register plus next-state logic live in this module.
- The output decode is a natural single combinational sub-module, `decodpa5000`: state in, {en1..en7, selmuxS, selmuxC, selmuxZ, busy, done} out.

## Test plan
- Reset held low, then released with `start`=0 -> all outputs stay 0 and the block remains in IDLE for 20 cycles.
- Single `start` pulse -> cycles 1 to 11 show exactly the step table:
  - en5 at cycle 2, en2 at 4, en6 at 6, en7 at 8, en1 at 10
  - en3 and en4 together at 11, with `done` at 11
  - `busy` high for cycles 1 to 11
- Impulse test with the datapath attached: CA1=CA2=0, CB0=1, CB1=-2, `uk`=1.0 then 0 for two more samples -> `yk` is 1.0, then -2.0, then 1.0.
- `start` held high continuously -> SHIFT goes directly to I1, `done` pulses every 11 cycles, and `busy` never drops.
- `start` pulsed during W2 of a run -> ignored; exactly one `done` follows.
- Reset asserted at cycle 6 of a run -> outputs go to 0 immediately. After release, the next `start` produces a full clean 11-cycle sequence.
